// File: rtl/ddmerge.sv
// rtl/ddmerge.sv - round-robin merge of per-VC 4-phase channels onto one VC-tagged output channel
module ddmerge #(
    parameter int VCN = 2,
    parameter int DW  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [VCN-1:0][DW-1:0] d_in,
    input  logic [VCN-1:0]         d_in_v,
    output logic [VCN-1:0]         d_in_a,
    output logic [DW-1:0]          d_out,
    output logic [VCN-1:0]         d_out_sel,
    input  logic                   d_out_a
);

    localparam int IW = (VCN > 1) ? $clog2(VCN) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RTZ  = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   g, g_nx;
    logic [IW-1:0]   rr_ptr, rr_ptr_nx;
    logic [DW-1:0]   d_out_nx;
    logic [VCN-1:0]  d_out_sel_nx;
    logic [VCN-1:0]  d_in_a_nx;

    logic [VCN-1:0]  req;
    logic [VCN-1:0]  pick_oh;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;
    logic            pick_ok;
    int              idx;

    // Scan from the highest offset down so the candidate closest to rr_ptr wins.
    always_comb begin
        req     = d_in_v & ~d_in_a;
        pick_ok = 1'b0;
        pick    = '0;
        cand    = '0;
        idx     = 0;
        pick_oh = '0;
        for (int k = VCN - 1; k >= 0; k--) begin
            idx  = (int'(rr_ptr) + k) % VCN;
            cand = IW'(idx);
            if (req[cand]) begin
                pick_ok = 1'b1;
                pick    = cand;
            end
        end
        for (int i = 0; i < VCN; i++) begin
            pick_oh[i] = (pick == IW'(i));
        end
    end

    always_comb begin
        state_nx     = state;
        g_nx         = g;
        rr_ptr_nx    = rr_ptr;
        d_out_nx     = d_out;
        d_out_sel_nx = d_out_sel;
        d_in_a_nx    = d_in_a;
        case (state)
            IDLE: begin
                // A stale output ack blocks new grants until the consumer returns to zero.
                if (!d_out_a && pick_ok) begin
                    d_out_nx     = d_in[pick];
                    d_out_sel_nx = pick_oh;
                    d_in_a_nx    = pick_oh;
                    g_nx         = pick;
                    state_nx     = SEND;
                end
            end
            SEND: begin
                if (d_out_a) begin
                    d_out_nx     = '0;
                    d_out_sel_nx = '0;
                    state_nx     = RTZ;
                end
            end
            RTZ: begin
                if (!d_out_a && !d_in_v[g]) begin
                    d_in_a_nx = '0;
                    rr_ptr_nx = (g == IW'(VCN - 1)) ? '0 : g + IW'(1);
                    state_nx  = IDLE;
                end
            end
            default: begin
                d_out_nx     = '0;
                d_out_sel_nx = '0;
                d_in_a_nx    = '0;
                state_nx     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            g         <= '0;
            rr_ptr    <= '0;
            d_out     <= '0;
            d_out_sel <= '0;
            d_in_a    <= '0;
        end else begin
            state     <= state_nx;
            g         <= g_nx;
            rr_ptr    <= rr_ptr_nx;
            d_out     <= d_out_nx;
            d_out_sel <= d_out_sel_nx;
            d_in_a    <= d_in_a_nx;
        end
    end

endmodule

// File: tb/tb_ddmerge.sv
// tb/tb_ddmerge.sv - self-checking bench for ddmerge (VCN=2, VCN=4, VCN=1 instances)
module tb_ddmerge;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int errors = 0;

    // VCN=2 instance
    logic [1:0][31:0] a_d = '0;
    logic [1:0]       a_v = '0;
    logic [1:0]       a_a;
    logic [31:0]      a_out;
    logic [1:0]       a_sel;
    logic             a_oa = 1'b0;

    // VCN=4 instance
    logic [3:0][7:0]  b_d = '0;
    logic [3:0]       b_v = '0;
    logic [3:0]       b_a;
    logic [7:0]       b_out;
    logic [3:0]       b_sel;
    logic             b_oa = 1'b0;
    logic [3:0]       b_want = '0;

    // VCN=1 instance
    logic [0:0][7:0]  c_d = '0;
    logic [0:0]       c_v = '0;
    logic [0:0]       c_a;
    logic [7:0]       c_out;
    logic [0:0]       c_sel;
    logic             c_oa = 1'b0;
    logic             c_want = 1'b0;

    ddmerge #(.VCN(2), .DW(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .d_in(a_d), .d_in_v(a_v), .d_in_a(a_a),
        .d_out(a_out), .d_out_sel(a_sel), .d_out_a(a_oa)
    );
    ddmerge #(.VCN(4), .DW(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .d_in(b_d), .d_in_v(b_v), .d_in_a(b_a),
        .d_out(b_out), .d_out_sel(b_sel), .d_out_a(b_oa)
    );
    ddmerge #(.VCN(1), .DW(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .d_in(c_d), .d_in_v(c_v), .d_in_a(c_a),
        .d_out(c_out), .d_out_sel(c_sel), .d_out_a(c_oa)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic int rr_pick(input logic [3:0] req, input int rr, input int n);
        for (int k = 0; k < n; k++) begin
            if (req[(rr + k) % n]) return (rr + k) % n;
        end
        return -1;
    endfunction

    // Reference model for the VCN=2 instance: protocol rules plus round-robin pointer.
    logic        mon_en = 1'b0;
    logic        primed = 1'b0;
    int          m_rr = 0;
    int          m_g = 0;
    int          g;
    logic [1:0]  exp_oh;
    logic [1:0]  s_v, p_sel, p_a;
    logic [1:0][31:0] s_d;
    logic [31:0] p_out;
    logic        s_oa;
    int          a_gq[$];

    always @(posedge clk) begin
        s_v  = a_v;
        s_d  = a_d;
        s_oa = a_oa;
    end

    always @(negedge clk) begin
        if (!mon_en) begin
            primed = 1'b0;
        end else begin
            if (primed) begin
                if (p_sel == 2'b00 && p_a == 2'b00) begin
                    if (!s_oa && s_v != 2'b00) begin
                        g      = rr_pick({2'b00, s_v}, m_rr, 2);
                        exp_oh = (g == 1) ? 2'b10 : 2'b01;
                        check("grant_sel", a_sel, exp_oh);
                        check("grant_ack", a_a, exp_oh);
                        check("grant_data", a_out, s_d[g]);
                        m_g = g;
                    end else begin
                        check("idle_sel", a_sel, 0);
                        check("idle_ack", a_a, 0);
                    end
                end else if (p_sel != 2'b00) begin
                    check("send_ack", a_a, p_a);
                    check("send_sel", a_sel, s_oa ? 2'b00 : p_sel);
                    check("send_data", a_out, s_oa ? 32'd0 : p_out);
                end else begin
                    if (!s_oa && !s_v[m_g]) begin
                        check("rtz_release", a_a, 0);
                        m_rr = (m_g + 1) % 2;
                    end else begin
                        check("rtz_hold", a_a, p_a);
                    end
                    check("rtz_sel", a_sel, 0);
                end
                check("one_ack", ($countones(a_a) <= 1), 1);
                if (a_sel == 2'b00) check("spacer_data", a_out, 0);
                if (p_sel == 2'b00 && a_sel != 2'b00) a_gq.push_back(a_sel[1] ? 1 : 0);
            end
            p_sel  = a_sel;
            p_a    = a_a;
            p_out  = a_out;
            primed = 1'b1;
        end
    end

    // Source/consumer agent for the VCN=2 instance.
    logic       a_auto = 1'b0;
    logic       a_rnd = 1'b0;
    logic [1:0] a_want = '0;

    always @(posedge clk) begin
        #1;
        if (a_auto) begin
            for (int i = 0; i < 2; i++) begin
                if (a_v[i] && a_a[i]) begin
                    if (!a_rnd || $urandom_range(0, 2) == 0) a_v[i] = 1'b0;
                end else if (!a_v[i] && !a_a[i] && a_want[i] && (!a_rnd || $urandom_range(0, 2) == 0)) begin
                    a_d[i] = $urandom;
                    a_v[i] = 1'b1;
                end
            end
            if (a_sel != 2'b00) begin
                if (!a_rnd || $urandom_range(0, 1) == 0) a_oa = 1'b1;
            end else if (!a_rnd || $urandom_range(0, 1) == 0) begin
                a_oa = 1'b0;
            end
        end
    end

    // One-shot sources and immediate consumer for VCN=4; continuous source for VCN=1.
    int         b_gq[$];
    logic [3:0] b_psel = '0;
    int         c_gq[$];
    logic       c_psel = 1'b0;
    int         cyc = 0;

    always @(posedge clk) begin
        cyc++;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (b_v[i] && b_a[i]) begin
                b_v[i] = 1'b0;
            end else if (!b_v[i] && !b_a[i] && b_want[i]) begin
                b_d[i]    = 8'($urandom);
                b_v[i]    = 1'b1;
                b_want[i] = 1'b0;
            end
        end
        b_oa = (b_sel != 4'b0000);
        if (c_v[0] && c_a[0]) begin
            c_v[0] = 1'b0;
        end else if (!c_v[0] && !c_a[0] && c_want) begin
            c_d[0] = 8'($urandom);
            c_v[0] = 1'b1;
        end
        c_oa = c_sel[0];
    end

    always @(negedge clk) begin
        if (rst_n && b_psel == 4'b0000 && b_sel != 4'b0000) begin
            for (int i = 0; i < 4; i++) begin
                if (b_sel[i]) begin
                    b_gq.push_back(i);
                    check("b_grant_data", b_out, b_d[i]);
                end
            end
        end
        b_psel = b_sel;
        if (rst_n && !c_psel && c_sel[0]) begin
            c_gq.push_back(cyc);
            check("c_grant_data", c_out, c_d[0]);
        end
        c_psel = c_sel[0];
    end

    task automatic do_reset;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        a_v    = '0;
        a_oa   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        m_rr  = 0;
        tick();
        mon_en = 1'b1;
    endtask

    initial begin
        tick();
        tick();
        check("rst_a_sel", a_sel, 0);
        check("rst_a_out", a_out, 0);
        check("rst_a_ack", a_a, 0);
        check("rst_b_sel", b_sel, 0);
        check("rst_c_sel", c_sel, 0);
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        // Single VC1 flit with a fixed word.
        a_d[1] = 32'hDEADBEEF;
        a_v    = 2'b10;
        tick();
        check("t2_sel", a_sel, 2'b10);
        check("t2_out", a_out, 32'hDEADBEEF);
        check("t2_ack", a_a, 2'b10);
        a_oa = 1'b1;
        tick();
        check("t2_spacer_sel", a_sel, 0);
        check("t2_spacer_out", a_out, 0);
        check("t2_ack_held", a_a, 2'b10);
        a_v  = 2'b00;
        a_oa = 1'b0;
        tick();
        check("t2_ack_rel", a_a, 0);

        // Stale output ack blocks the grant.
        a_oa = 1'b1;
        tick();
        a_d[0] = 32'h12345678;
        a_v    = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_no_grant", a_sel, 0);
        end
        a_oa = 1'b0;
        tick();
        check("t4_grant_sel", a_sel, 2'b01);
        check("t4_grant_out", a_out, 32'h12345678);
        a_v  = 2'b00;
        a_oa = 1'b1;
        tick();
        a_oa = 1'b0;
        tick();

        // Source withdraws its request early; release still waits for the output ack to fall.
        a_d[0] = 32'hA5A5_5A5A;
        a_v    = 2'b01;
        tick();
        check("t5_sel", a_sel, 2'b01);
        a_v = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_ack_wait", a_a, 2'b01);
        end
        a_oa = 1'b1;
        tick();
        check("t5_rtz_sel", a_sel, 0);
        check("t5_rtz_ack", a_a, 2'b01);
        tick();
        check("t5_rtz_hold", a_a, 2'b01);
        a_oa = 1'b0;
        tick();
        check("t5_release", a_a, 0);
        a_d[0] = 32'h0000_0001;
        a_d[1] = 32'h0000_0002;
        a_v    = 2'b11;
        tick();
        check("t5_rr_next", a_sel, 2'b10);

        // Asynchronous reset while VC1 is in SEND.
        mon_en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("t1_async_out", a_out, 0);
        check("t1_async_sel", a_sel, 0);
        check("t1_async_ack", a_a, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t1_first_grant", a_sel, 2'b01);
        a_v  = 2'b00;
        a_oa = 1'b1;
        tick();
        a_oa = 1'b0;
        tick();

        // Continuous requests alternate.
        do_reset();
        a_gq.delete();
        a_auto = 1'b1;
        a_rnd  = 1'b0;
        a_want = 2'b11;
        for (int t = 0; t < 300 && a_gq.size() < 6; t++) tick();
        check("t3_count", (a_gq.size() >= 6), 1);
        for (int k = 0; k < 6 && k < a_gq.size(); k++) check("t3_order", a_gq[k], k % 2);

        // Randomised traffic against the reference model.
        a_rnd = 1'b1;
        a_gq.delete();
        for (int t = 0; t < 3000; t++) begin
            if (t % 40 == 0) a_want = 2'($urandom_range(0, 3));
            tick();
        end
        check("rand_progress", (a_gq.size() > 50), 1);
        a_want = 2'b00;
        for (int t = 0; t < 200 && (a_v != 2'b00 || a_a != 2'b00 || a_oa); t++) tick();
        check("rand_drain", {a_v, a_a, a_oa}, 0);
        a_auto = 1'b0;

        // VCN=4: bring rr_ptr to 2, then requests 1011.
        b_gq.delete();
        b_want = 4'b0001;
        for (int t = 0; t < 50 && !(b_gq.size() >= 1 && b_want == 0 && b_v == 0 && b_a == 0); t++) tick();
        b_want = 4'b0010;
        for (int t = 0; t < 50 && !(b_gq.size() >= 2 && b_want == 0 && b_v == 0 && b_a == 0); t++) tick();
        b_want = 4'b1011;
        for (int t = 0; t < 100 && !(b_gq.size() >= 5 && b_want == 0 && b_v == 0 && b_a == 0); t++) tick();
        check("b_count", b_gq.size(), 5);
        if (b_gq.size() >= 5) begin
            check("b_g0", b_gq[0], 0);
            check("b_g1", b_gq[1], 1);
            check("b_g2", b_gq[2], 3);
            check("b_g3", b_gq[3], 0);
            check("b_g4", b_gq[4], 1);
        end

        // VCN=1: back-to-back flits at the minimum spacing.
        c_gq.delete();
        c_want = 1'b1;
        for (int t = 0; t < 100 && c_gq.size() < 5; t++) tick();
        c_want = 1'b0;
        check("c_count", (c_gq.size() >= 5), 1);
        for (int k = 1; k < 5 && k < c_gq.size(); k++) check("c_spacing", c_gq[k] - c_gq[k-1], 3);
        for (int t = 0; t < 10; t++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
